// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: shared ISA widths, MIPS opcode/funct encodings and helpers for the mul/div unit.
package mul_div_unit_pkg;
    localparam int WORD = 32;
    localparam int OPC  = 6;
    localparam int FUN  = 6;

    localparam logic [OPC-1:0] OPC_SPECIAL = 6'h00;
    localparam logic [FUN-1:0] FUN_MULT    = 6'h18;
    localparam logic [FUN-1:0] FUN_MULTU   = 6'h19;
    localparam logic [FUN-1:0] FUN_DIV     = 6'h1A;
    localparam logic [FUN-1:0] FUN_DIVU    = 6'h1B;

    function automatic logic md_accept(input logic [OPC-1:0] opc, input logic [FUN-1:0] fun);
        return opc == OPC_SPECIAL && fun inside {FUN_MULT, FUN_MULTU, FUN_DIV, FUN_DIVU};
    endfunction

    // 0x80000000 maps to itself, which reads correctly as 2^31 when unsigned.
    function automatic logic [WORD-1:0] mag(input logic [WORD-1:0] v, input logic sgn);
        return (sgn && v[WORD-1]) ? -v : v;
    endfunction
endpackage

// File: rtl/mul_div_step.sv
// mul_div_step: one radix-2 shift-add multiply or restoring-divide iteration.
module mul_div_step
    import mul_div_unit_pkg::*;
(
    input  logic              is_div_i,
    input  logic [2*WORD-1:0] acc_i,
    input  logic [WORD-1:0]   opnd_i,
    output logic [2*WORD-1:0] acc_o,
    output logic              q_o
);
    logic [WORD:0]   sum;
    logic [WORD:0]   rem;
    logic [WORD-1:0] rem_sub;

    // Divide: acc = {remainder, dividend bits still to consume / quotient bits so far}.
    assign rem     = {acc_i[2*WORD-1:WORD], acc_i[WORD-1]};
    assign rem_sub = rem[WORD-1:0] - opnd_i;
    assign q_o     = is_div_i && (rem >= {1'b0, opnd_i});
    // Multiply: acc = {partial product, multiplier bits still to consume}.
    assign sum     = {1'b0, acc_i[2*WORD-1:WORD]} + {1'b0, acc_i[0] ? opnd_i : '0};

    assign acc_o = is_div_i ? {q_o ? rem_sub : rem[WORD-1:0], acc_i[WORD-2:0], 1'b0}
                            : {sum, acc_i[WORD-1:1]};
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU engine, 34 cycles from accept to a one-cycle done pulse.
module mul_div_unit
    import mul_div_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OPC-1:0]  opcode,
    input  logic [FUN-1:0]  funct,
    input  logic [WORD-1:0] srcA,
    input  logic [WORD-1:0] srcB,
    output logic            busy,
    output logic            done,
    output logic [WORD-1:0] lo,
    output logic [WORD-1:0] hi
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state_q;
    logic [4:0]        cnt_q;
    logic              is_div_q, neg_q, neg_rem_q, dz_q;
    logic [WORD-1:0]   opnd_q, raw_a_q, lo_q, hi_q;
    logic [2*WORD-1:0] acc_q, acc_d, acc_n;
    logic              q_bit, sgn;
    logic [WORD-1:0]   mag_a, mag_b;

    assign sgn   = ~funct[0];
    assign mag_a = mag(srcA, sgn);
    assign mag_b = mag(srcB, sgn);
    assign acc_d = {acc_n[2*WORD-1:1], acc_n[0] | q_bit};

    mul_div_step u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (acc_n),
        .q_o      (q_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            opnd_q    <= '0;
            raw_a_q   <= '0;
            acc_q     <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
        end else begin
            case (state_q)
                IDLE: if (start && md_accept(opcode, funct)) begin
                    state_q   <= CALC;
                    cnt_q     <= '0;
                    is_div_q  <= funct[1];
                    neg_q     <= sgn && (srcA[WORD-1] ^ srcB[WORD-1]);
                    neg_rem_q <= sgn && srcA[WORD-1];
                    dz_q      <= srcB == '0;
                    raw_a_q   <= srcA;
                    opnd_q    <= funct[1] ? mag_b : mag_a;
                    acc_q     <= {{WORD{1'b0}}, funct[1] ? mag_a : mag_b};
                end
                CALC: begin
                    acc_q   <= acc_d;
                    cnt_q   <= cnt_q + 5'd1;
                    state_q <= (cnt_q == 5'd31) ? FIX : CALC;
                end
                FIX: begin
                    state_q <= DONE;
                    if (is_div_q && dz_q) begin
                        lo_q <= '1;
                        hi_q <= raw_a_q;
                    end else if (is_div_q) begin
                        lo_q <= neg_q ? -acc_q[WORD-1:0] : acc_q[WORD-1:0];
                        hi_q <= neg_rem_q ? -acc_q[2*WORD-1:WORD] : acc_q[2*WORD-1:WORD];
                    end else begin
                        {hi_q, lo_q} <= neg_q ? -acc_q : acc_q;
                    end
                end
                DONE: state_q <= IDLE;
            endcase
        end
    end

    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    assign lo   = lo_q;
    assign hi   = hi_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench; expected {hi,lo} come from plain 64-bit integer arithmetic.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        clk = 0, rst = 1, start = 0;
    logic [5:0]  opcode = 0, funct = 0;
    logic [31:0] srcA = 0, srcB = 0;
    logic        busy, done;
    logic [31:0] lo, hi;

    int total = 0, bad = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_exp = 0;

    mul_div_unit dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .funct(funct),
        .srcA(srcA), .srcB(srcB), .busy(busy), .done(done), .lo(lo), .hi(hi)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endfunction

    // Returns {hi, lo}.
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        if (f == FUN_MULT) p = sa * sb;
        else if (f == FUN_MULTU) p = ua * ub;
        else if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
            q = (f == FUN_DIV) ? sa / sb : ua / ub;
            r = (f == FUN_DIV) ? sa % sb : ua % ub;
            p = {r[31:0], q[31:0]};
        end
        return p;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
            else check("result", {hi, lo}, exp_q.pop_front());
        end
    end

    // Called at posedge+1 with the unit idle; returns at posedge+1 of cycle 1.
    task automatic issue(input logic [5:0] opc, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        opcode = opc; funct = f; srcA = a; srcB = b; start = 1;
        @(posedge clk); #1;
        start = 0; srcA = $urandom; srcB = $urandom;
    endtask

    task automatic wait_done();
        int n;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) break;
        end
        if (n == 40) check("done_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        last_exp = model(f, a, b);
        exp_q.push_back(last_exp);
        issue(OPC_SPECIAL, f, a, b);
        wait_done();
    endtask

    initial begin
        logic saw_done;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_lohi", {hi, lo}, 64'd0);
        rst = 0;
        @(posedge clk); #1;

        last_exp = model(FUN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("model_multu", last_exp, 64'hFFFF_FFFE_0000_0001);
        exp_q.push_back(last_exp);
        issue(OPC_SPECIAL, FUN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            check($sformatf("busy_c%0d", k), 64'(busy), 64'(k <= 34));
            check($sformatf("done_c%0d", k), 64'(done), 64'(k == 34));
        end
        @(posedge clk); #1;

        run_op(FUN_MULT, 32'hFFFF_FFFD, 32'h5);
        run_op(FUN_MULT, 32'h8000_0000, 32'h8000_0000);
        run_op(FUN_DIV, 32'hFFFF_FFF9, 32'h2);
        run_op(FUN_DIVU, 32'h7, 32'h2);
        run_op(FUN_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(FUN_DIVU, 32'h5, 32'h0);
        run_op(FUN_DIV, 32'hFFFF_FFFB, 32'h0);
        run_op(FUN_DIV, 32'h7, 32'hFFFF_FFFE);
        check("model_mult_min", model(FUN_MULT, 32'h8000_0000, 32'h8000_0000), 64'h4000_0000_0000_0000);
        check("model_div_neg", model(FUN_DIV, 32'hFFFF_FFF9, 32'h2), 64'hFFFF_FFFF_FFFF_FFFD);

        issue(OPC_SPECIAL, 6'h10, 32'h1234, 32'h5678);
        check("mfhi_busy", 64'(busy), 64'd0);
        issue(6'h01, FUN_MULT, 32'h3, 32'h3);
        repeat (3) @(negedge clk);
        check("ignored_busy", 64'(busy), 64'd0);
        check("ignored_lohi", {hi, lo}, last_exp);
        @(posedge clk); #1;

        last_exp = model(FUN_MULTU, 32'h0001_0003, 32'h0002_0005);
        exp_q.push_back(last_exp);
        issue(OPC_SPECIAL, FUN_MULTU, 32'h0001_0003, 32'h0002_0005);
        repeat (9) @(posedge clk);
        #1;
        opcode = OPC_SPECIAL; funct = FUN_DIVU; srcA = 32'd100; srcB = 32'd3; start = 1;
        @(posedge clk); #1;
        start = 0;
        check("busy_during_second_start", 64'(busy), 64'd1);
        wait_done();

        issue(OPC_SPECIAL, FUN_MULT, 32'h1111_1111, 32'h2222_2222);
        repeat (19) @(posedge clk);
        #1;
        rst = 1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_lohi", {hi, lo}, 64'd0);
        @(posedge clk); #1;
        opcode = OPC_SPECIAL; funct = FUN_DIVU; srcA = 32'd9; srcB = 32'd2; start = 1;
        @(posedge clk); #1;
        rst = 0; start = 0;
        check("start_in_rst_busy", 64'(busy), 64'd0);
        saw_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        check("no_done_after_rst", 64'(saw_done), 64'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            logic [5:0]  f;
            logic [31:0] a, b;
            f = FUN_MULT + 6'($urandom_range(0, 3));
            a = pick();
            b = pick();
            run_op(f, a, b);
        end

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit for the MIPS core. Executes MULT, MULTU, DIV and DIVU over 34 cycles and produces the 64-bit {hi, lo} result. On completion it raises a one-cycle `done` pulse that drives the register file's lo/hi write strobe, with `lo`/`hi` driving its lo/hi write-data inputs. It sits between the decode/operand-read stage and the lo/hi registers.

## Interface
- No parameters. Widths come from the `WORD`, `OPC` and `FUN` macros in ISA.v.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `start  in  1`: request. Sampled only in IDLE.
- `opcode  in  6`: instruction opcode.
- `funct  in  6`: instruction funct field.
- `srcA  in  32`: rs operand (multiplicand or dividend).
- `srcB  in  32`: rt operand (multiplier or divisor).
- `busy  out  1`: high whenever the state is not IDLE.
- `done  out  1`: one-cycle pulse; `lo`/`hi` are valid while it is high.
- `lo  out  32`: product low word, or quotient.
- `hi  out  32`: product high word, or remainder.

## Operation
- Accepted op: `start` is high, `opcode == OPC_SPECIAL` and funct is one of FUN_MULT (0x18), FUN_MULTU (0x19), FUN_DIV (0x1A), FUN_DIVU (0x1B).
  - Any other op with `start` high is ignored: the unit stays IDLE and no flag changes.
- States:
  - IDLE: on an accepted op, go to CALC.
  - CALC: 32 iterations, then go to FIX.
  - FIX: sign correction and special cases, then go to DONE.
  - DONE: `done` high for one cycle, then go to IDLE.
- On accept, latch the op kind, the sign flags and the operand magnitudes.
  - Signed ops: magnitude = two's-complement absolute value. 0x80000000 gives magnitude 2^31 as unsigned.
  - Unsigned ops: operands are used raw.
- Multiply (radix-2 shift-add):
  - 64-bit accumulator, 32 iterations, one multiplier bit per cycle, LSB first.
  - MULT result is the 64-bit negation of the magnitude product iff exactly one operand is negative.
- Divide (restoring):
  - 32 iterations produce one quotient bit per cycle, MSB first, using a 33-bit partial remainder.
  - Signed quotient is negated iff the operand signs differ.
  - Signed remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0 (falls out of the magnitude path).
- Divide by zero (both DIV and DIVU): lo = 0xFFFFFFFF, hi = srcA as latched. Sign correction is bypassed.
- `lo`/`hi` are registered in FIX and hold their value until the next FIX. They are not cleared on return to IDLE.
- `start` while busy is ignored. Nothing is queued.
- Operand inputs are don't-care after the accept edge.

## Timing
- Cycle 0: `start` is high in IDLE and accepted at the edge ending cycle 0.
- Cycles 1–32: CALC. Iteration counter runs 0..31 and wraps to FIX after 31.
- Cycle 33: FIX.
- Cycle 34: DONE, so `done` = 1 and `lo`/`hi` are valid. Latency is 34 cycles, start to done.
- Cycle 35: IDLE. A new `start` in cycle 35 is accepted, so back-to-back throughput is one op per 35 cycles.
- `busy` is high in cycles 1–34.
- Reset values: state = IDLE, `busy` = 0, `done` = 0, `lo` = 0, `hi` = 0, counter = 0.
- Reset mid-operation: immediate return to IDLE. No `done` pulse; the partial result is discarded.
- Reset released in the same cycle as `start`: `start` is ignored if `rst` is high at the clock edge.

## Structure
- ISA.v is the shared header and supplies `WORD`, `OPC`, `FUN`, `OPC_SPECIAL` and the FUN_MULT/MULTU/DIV/DIVU macros.
  - Add these macros to ISA.v if any is missing.
- State encoding is a 2-bit localparam set (IDLE, CALC, FIX, DONE) local to the block.
- One combinational sub-module, `mul_div_step`, performs one iteration.
  - Inputs: op kind, accumulator/remainder and operand.
  - Outputs: next accumulator/remainder and the next quotient bit.
- Everything else is in the top module.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001; `done` in cycle 34 only; `busy` high in cycles 1–34.
- MULT −3 × 5 (0xFFFFFFFD, 0x5) → hi = 0xFFFFFFFF, lo = 0xFFFFFFF1. MULT 0x80000000 × 0x80000000 → hi = 0x40000000, lo = 0.
- DIV −7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU 7 / 2 → lo = 3, hi = 1.
- DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0. DIVU 5 / 0 → lo = 0xFFFFFFFF, hi = 5.
- Concurrency: a second `start` in cycle 10 is ignored and the first result is unchanged. Then `rst` pulsed in cycle 20 of a new op → `busy` falls immediately and `done` never pulses.
- `start` with funct = MFHI (0x10) → `busy` stays 0 and `lo`/`hi` keep their previous values.
